repairval_module_initiator: RTL and testbench

// Initiating (module) side of MBINIT.REPAIRVAL sideband handshake; pairs with partner-side responder.

---
 rtl/repairval_module_initiator.sv | 159 +++++++++++++++
 tb/tb_repairval_module_initiator.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/repairval_module_initiator.sv
// ============================================================================
// Module  : repairval_module_initiator
// Brief   : Initiator side of the MBINIT.REPAIRVAL sideband handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module repairval_module_initiator #(
    parameter int TIMEOUT_CYCLES = 16'd8000,
    parameter int CNT_W          = 16
) (
    input  logic       CLK,
    input  logic       rst_n,
    input  logic       i_REPAIRCLK_end,
    input  logic [3:0] i_Rx_SbMessage,
    input  logic       i_msg_valid,
    input  logic       i_Rx_VAL_result,
    input  logic       i_Busy_SideBand,
    input  logic       i_falling_edge_busy,
    input  logic       i_VAL_pattern_done,
    output logic [3:0] o_TX_SbMessage,
    output logic       o_ValidOutData_Module,
    output logic       o_VAL_pattern_en,
    output logic       o_VAL_result,
    output logic       o_MBINIT_REPAIRVAL_Module_end,
    output logic       o_train_error
);

    localparam logic [3:0] c_MSG_NONE        = 4'b0000;
    localparam logic [3:0] c_MSG_INIT_REQ    = 4'b0001;
    localparam logic [3:0] c_MSG_INIT_RESP   = 4'b0010;
    localparam logic [3:0] c_MSG_RESULT_REQ  = 4'b0011;
    localparam logic [3:0] c_MSG_RESULT_RESP = 4'b0100;
    localparam logic [3:0] c_MSG_DONE_REQ    = 4'b0101;
    localparam logic [3:0] c_MSG_DONE_RESP   = 4'b0110;

    localparam logic [3:0] c_IDLE             = 4'd0;
    localparam logic [3:0] c_WAIT_BUSY_INIT   = 4'd1;
    localparam logic [3:0] c_SEND_INIT_REQ    = 4'd2;
    localparam logic [3:0] c_WAIT_INIT_RESP   = 4'd3;
    localparam logic [3:0] c_SEND_PATTERN     = 4'd4;
    localparam logic [3:0] c_WAIT_BUSY_RESULT = 4'd5;
    localparam logic [3:0] c_SEND_RESULT_REQ  = 4'd6;
    localparam logic [3:0] c_WAIT_RESULT_RESP = 4'd7;
    localparam logic [3:0] c_WAIT_BUSY_DONE   = 4'd8;
    localparam logic [3:0] c_SEND_DONE_REQ    = 4'd9;
    localparam logic [3:0] c_WAIT_DONE_RESP   = 4'd10;
    localparam logic [3:0] c_COMPLETE         = 4'd11;
    localparam logic [3:0] c_ERROR            = 4'd12;

    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_in_wait;
    logic             w_timeout;
    logic             w_init_resp;
    logic             w_result_resp;
    logic             w_done_resp;
    logic [3:0]       w_tx_msg;
    logic             w_tx_valid;
    logic             w_pat_en;
    logic             w_end;
    logic             w_err;

    assign w_init_resp   = i_msg_valid && (i_Rx_SbMessage == c_MSG_INIT_RESP);
    assign w_result_resp = i_msg_valid && (i_Rx_SbMessage == c_MSG_RESULT_RESP);
    assign w_done_resp   = i_msg_valid && (i_Rx_SbMessage == c_MSG_DONE_RESP);
    assign w_in_wait     = (r_state == c_WAIT_INIT_RESP) || (r_state == c_WAIT_RESULT_RESP) ||
                           (r_state == c_WAIT_DONE_RESP);
    assign w_timeout     = (r_cnt == c_TO_LAST);

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Matching responses are checked before the timeout so they win on the last cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:             if (i_REPAIRCLK_end)     w_next_state = c_WAIT_BUSY_INIT;
            c_WAIT_BUSY_INIT:   if (!i_Busy_SideBand)    w_next_state = c_SEND_INIT_REQ;
            c_SEND_INIT_REQ:    if (i_falling_edge_busy) w_next_state = c_WAIT_INIT_RESP;
            c_WAIT_INIT_RESP: begin
                if (w_init_resp)    w_next_state = c_SEND_PATTERN;
                else if (w_timeout) w_next_state = c_ERROR;
            end
            c_SEND_PATTERN:     if (i_VAL_pattern_done)  w_next_state = c_WAIT_BUSY_RESULT;
            c_WAIT_BUSY_RESULT: if (!i_Busy_SideBand)    w_next_state = c_SEND_RESULT_REQ;
            c_SEND_RESULT_REQ:  if (i_falling_edge_busy) w_next_state = c_WAIT_RESULT_RESP;
            c_WAIT_RESULT_RESP: begin
                if (w_result_resp)  w_next_state = i_Rx_VAL_result ? c_WAIT_BUSY_DONE : c_ERROR;
                else if (w_timeout) w_next_state = c_ERROR;
            end
            c_WAIT_BUSY_DONE:   if (!i_Busy_SideBand)    w_next_state = c_SEND_DONE_REQ;
            c_SEND_DONE_REQ:    if (i_falling_edge_busy) w_next_state = c_WAIT_DONE_RESP;
            c_WAIT_DONE_RESP: begin
                if (w_done_resp)    w_next_state = c_COMPLETE;
                else if (w_timeout) w_next_state = c_ERROR;
            end
            c_COMPLETE:         w_next_state = c_COMPLETE;
            c_ERROR:            w_next_state = c_ERROR;
            default:            w_next_state = c_IDLE;
        endcase
        if ((r_state != c_IDLE) && !i_REPAIRCLK_end) begin
            w_next_state = c_IDLE;
        end
    end

    always_comb begin
        w_tx_msg   = c_MSG_NONE;
        w_tx_valid = 1'b0;
        w_pat_en   = 1'b0;
        w_end      = 1'b0;
        w_err      = 1'b0;
        case (w_next_state)
            c_SEND_INIT_REQ:   begin w_tx_msg = c_MSG_INIT_REQ;   w_tx_valid = 1'b1; end
            c_SEND_RESULT_REQ: begin w_tx_msg = c_MSG_RESULT_REQ; w_tx_valid = 1'b1; end
            c_SEND_DONE_REQ:   begin w_tx_msg = c_MSG_DONE_REQ;   w_tx_valid = 1'b1; end
            c_SEND_PATTERN:    w_pat_en = 1'b1;
            c_COMPLETE:        w_end    = 1'b1;
            c_ERROR:           w_err    = 1'b1;
            default:           ;
        endcase
    end

    // Outputs are registered from next_state so they line up with the state register.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt                         <= '0;
            o_TX_SbMessage                <= c_MSG_NONE;
            o_ValidOutData_Module         <= 1'b0;
            o_VAL_pattern_en              <= 1'b0;
            o_VAL_result                  <= 1'b0;
            o_MBINIT_REPAIRVAL_Module_end <= 1'b0;
            o_train_error                 <= 1'b0;
        end else begin
            r_cnt                         <= w_in_wait ? r_cnt + 1'b1 : '0;
            o_TX_SbMessage                <= w_tx_msg;
            o_ValidOutData_Module         <= w_tx_valid;
            o_VAL_pattern_en              <= w_pat_en;
            o_MBINIT_REPAIRVAL_Module_end <= w_end;
            o_train_error                 <= w_err;
            if (w_next_state == c_IDLE) begin
                o_VAL_result <= 1'b0;
            end else if ((r_state == c_WAIT_RESULT_RESP) && w_result_resp) begin
                o_VAL_result <= i_Rx_VAL_result;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_repairval_module_initiator.sv
// ============================================================================
// Module  : tb_repairval_module_initiator
// Brief   : Directed self-checking bench for repairval_module_initiator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_repairval_module_initiator;

    logic       CLK = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] rx_msg;
    logic       msg_valid;
    logic       rx_res;
    logic       busy;
    logic       fe_busy;
    logic       pat_done;
    logic [3:0] tx_msg;
    logic       tx_valid;
    logic       pat_en;
    logic       val_res;
    logic       mod_end;
    logic       train_err;

    int checks = 0;
    int errors = 0;
    logic [3:0] tx_log[$];
    logic       prev_valid = 1'b0;

    repairval_module_initiator #(
        .TIMEOUT_CYCLES(16),
        .CNT_W         (16)
    ) dut (
        .CLK                          (CLK),
        .rst_n                        (rst_n),
        .i_REPAIRCLK_end              (en),
        .i_Rx_SbMessage               (rx_msg),
        .i_msg_valid                  (msg_valid),
        .i_Rx_VAL_result              (rx_res),
        .i_Busy_SideBand              (busy),
        .i_falling_edge_busy          (fe_busy),
        .i_VAL_pattern_done           (pat_done),
        .o_TX_SbMessage               (tx_msg),
        .o_ValidOutData_Module        (tx_valid),
        .o_VAL_pattern_en             (pat_en),
        .o_VAL_result                 (val_res),
        .o_MBINIT_REPAIRVAL_Module_end(mod_end),
        .o_train_error                (train_err)
    );

    always #5 CLK = ~CLK;

    // Record each new transmitted request on its first valid cycle.
    always @(negedge CLK) begin
        if (tx_valid && !prev_valid) tx_log.push_back(tx_msg);
        prev_valid <= tx_valid;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_msg(input logic [3:0] code, input logic res);
        rx_msg = code; msg_valid = 1'b1; rx_res = res;
        tick();
        rx_msg = 4'h0; msg_valid = 1'b0; rx_res = 1'b0;
    endtask

    task automatic pulse_fe();
        fe_busy = 1'b1; tick(); fe_busy = 1'b0;
    endtask

    task automatic pulse_pd();
        pat_done = 1'b1; tick(); pat_done = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Abort to IDLE, restart, and stop on the edge that enters WAIT_INIT_RESP.
    task automatic go_to_wait_init(output bit ok);
        en = 1'b0; busy = 1'b0; tick();
        en = 1'b1;
        wait_valid(ok);
        pulse_fe();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; rx_msg = 4'h0; msg_valid = 1'b0; rx_res = 1'b0;
        busy = 1'b0; fe_busy = 1'b0; pat_done = 1'b0;
        tick(); tick();
        checks++;
        if ({tx_msg, tx_valid, pat_en, val_res, mod_end, train_err} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected 000000000",
                     {tx_msg, tx_valid, pat_en, val_res, mod_end, train_err});
        end
        rst_n = 1'b1; en = 1'b1;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_msg !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b msg=%h, expected 0 0", tx_valid, tx_msg);
        end
        en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_happy_path();
        bit ok;
        tx_log.delete();
        go_to_wait_init(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL happy_init_req: no valid within bound"); end
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++; $display("FAIL happy_init_done: valid=%b, expected 0", tx_valid);
        end
        send_msg(4'h2, 1'b0);
        checks++;
        if (pat_en !== 1'b1) begin errors++; $display("FAIL happy_pattern_en: got %b, expected 1", pat_en); end
        pulse_pd();
        checks++;
        if (pat_en !== 1'b0) begin errors++; $display("FAIL happy_pattern_off: got %b, expected 0", pat_en); end
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_msg !== 4'h3) begin
            errors++; $display("FAIL happy_result_req: valid=%b msg=%h, expected 1 3", tx_valid, tx_msg);
        end
        pulse_fe();
        send_msg(4'h4, 1'b1);
        checks++;
        if (val_res !== 1'b1) begin errors++; $display("FAIL happy_val_result: got %b, expected 1", val_res); end
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_msg !== 4'h5) begin
            errors++; $display("FAIL happy_done_req: valid=%b msg=%h, expected 1 5", tx_valid, tx_msg);
        end
        pulse_fe();
        send_msg(4'h6, 1'b0);
        tick(); tick();
        checks++;
        if (mod_end !== 1'b1 || train_err !== 1'b0 || val_res !== 1'b1) begin
            errors++;
            $display("FAIL happy_complete: end=%b err=%b res=%b, expected 1 0 1", mod_end, train_err, val_res);
        end
        checks++;
        if (tx_log.size() != 3 || tx_log[0] !== 4'h1 || tx_log[1] !== 4'h3 || tx_log[2] !== 4'h5) begin
            errors++;
            $display("FAIL happy_tx_order: got %p, expected '{1,3,5}", tx_log);
        end
        en = 1'b0;
        tick();
        checks++;
        if (mod_end !== 1'b0 || val_res !== 1'b0) begin
            errors++; $display("FAIL complete_abort: end=%b res=%b, expected 0 0", mod_end, val_res);
        end
    endtask

    task automatic test_fail_result();
        bit ok;
        bit done_seen;
        tx_log.delete();
        go_to_wait_init(ok);
        send_msg(4'h2, 1'b0);
        pulse_pd();
        tick();
        pulse_fe();
        send_msg(4'h4, 1'b0);
        checks++;
        if (train_err !== 1'b1 || mod_end !== 1'b0 || val_res !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL fail_result: err=%b end=%b res=%b ok=%b, expected 1 0 0 1",
                     train_err, mod_end, val_res, ok);
        end
        for (int i = 0; i < 5; i++) tick();
        done_seen = 1'b0;
        foreach (tx_log[i]) if (tx_log[i] == 4'h5) done_seen = 1'b1;
        checks++;
        if (done_seen || tx_valid !== 1'b0 || train_err !== 1'b1) begin
            errors++;
            $display("FAIL fail_no_done: done_seen=%b valid=%b err=%b, expected 0 0 1",
                     done_seen, tx_valid, train_err);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        go_to_wait_init(ok);
        send_msg(4'h6, 1'b0);
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (train_err !== 1'b0) begin
            errors++; $display("FAIL timeout_early: err=%b at cycle 15, expected 0", train_err);
        end
        tick();
        checks++;
        if (train_err !== 1'b1 || pat_en !== 1'b0 || !ok) begin
            errors++;
            $display("FAIL timeout_error: err=%b pat_en=%b ok=%b at cycle 16, expected 1 0 1",
                     train_err, pat_en, ok);
        end
    endtask

    task automatic test_noise_boundary();
        bit ok;
        go_to_wait_init(ok);
        send_msg(4'h6, 1'b0);
        checks++;
        if (pat_en !== 1'b0 || train_err !== 1'b0 || !ok) begin
            errors++; $display("FAIL noise_wrong_code: pat_en=%b err=%b, expected 0 0", pat_en, train_err);
        end
        rx_msg = 4'h2; msg_valid = 1'b0;
        tick();
        rx_msg = 4'h0;
        checks++;
        if (pat_en !== 1'b0) begin
            errors++; $display("FAIL noise_not_valid: pat_en=%b, expected 0", pat_en);
        end
        for (int i = 0; i < 13; i++) tick();
        send_msg(4'h2, 1'b0);
        checks++;
        if (pat_en !== 1'b1 || train_err !== 1'b0) begin
            errors++;
            $display("FAIL match_on_last_cycle: pat_en=%b err=%b, expected 1 0", pat_en, train_err);
        end
    endtask

    task automatic test_busy_stall();
        bit stayed_low;
        en = 1'b0; tick();
        busy = 1'b1; en = 1'b1;
        stayed_low = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid !== 1'b0) stayed_low = 1'b0;
        end
        checks++;
        if (!stayed_low) begin errors++; $display("FAIL busy_stall: valid rose while busy, expected 0"); end
        busy = 1'b0;
        tick();
        checks++;
        if (tx_valid !== 1'b1 || tx_msg !== 4'h1) begin
            errors++; $display("FAIL busy_release: valid=%b msg=%h, expected 1 1", tx_valid, tx_msg);
        end
    endtask

    task automatic test_abort();
        bit ok;
        go_to_wait_init(ok);
        send_msg(4'h2, 1'b0);
        checks++;
        if (pat_en !== 1'b1 || !ok) begin errors++; $display("FAIL abort_setup: pat_en=%b, expected 1", pat_en); end
        en = 1'b0; pat_done = 1'b1;
        tick();
        pat_done = 1'b0;
        checks++;
        if ({tx_msg, tx_valid, pat_en, val_res, mod_end, train_err} !== 9'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %b, expected 000000000",
                     {tx_msg, tx_valid, pat_en, val_res, mod_end, train_err});
        end
        tick(); tick();
        checks++;
        if (tx_valid !== 1'b0 || pat_en !== 1'b0) begin
            errors++; $display("FAIL abort_idle_hold: valid=%b pat_en=%b, expected 0 0", tx_valid, pat_en);
        end
    endtask

    initial begin
        test_reset();
        test_happy_path();
        test_fail_result();
        test_timeout();
        test_noise_boundary();
        test_busy_stall();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
